// File: rtl/fifo_spram_2bank_if.sv
// ----------------------------------------------------------------------------
// fifo_spram_2bank_if
// Streaming handshake bundle for fifo_spram_2bank.
//   in_data / in_valid / in_ready    : producer -> FIFO push channel
//   out_data / out_valid / out_ready : FIFO -> consumer pop channel
// Modports:
//   master : the side that talks to the FIFO (drives pushes, accepts pops)
//   slave  : the FIFO itself
// ----------------------------------------------------------------------------
interface fifo_spram_2bank_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fifo_spram_2bank.sv
// ----------------------------------------------------------------------------
// fifo_spram_2bank
// Valid/ready FIFO built from two single-port RAM banks (even addresses in
// bank 0, odd in bank 1). A 2-entry prefetch buffer feeds the output, and a
// bypass path lets words go straight into that buffer while the RAM is empty.
// Ports:
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   flush        : synchronous clear of all contents
//   bus          : push/pop handshake bundle (slave modport)
//   count        : words held (RAM + in-flight read + prefetch buffer)
//   almost_full  : count >= AFULL_THRESH
//   almost_empty : count <= AEMPTY_THRESH
// ----------------------------------------------------------------------------
module fifo_spram_2bank #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int BANK_AW       = $clog2(FIFO_DEPTH / 2),
  parameter int CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  fifo_spram_2bank_if.slave     bus,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int PTR_W      = BANK_AW + 1;
  localparam int BANK_DEPTH = FIFO_DEPTH / 2;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  // Registered state
  logic [PTR_W-1:0]      wr_ptr_reg,   wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg,   rd_ptr_next;
  logic [CNT_W-1:0]      ram_cnt_reg,  ram_cnt_next;
  logic [CNT_W-1:0]      count_reg,    count_next;
  logic [1:0]            obuf_cnt_reg, obuf_cnt_next;
  logic [DATA_WIDTH-1:0] obuf0_reg,    obuf0_next;   // head of the buffer
  logic [DATA_WIDTH-1:0] obuf1_reg,    obuf1_next;
  logic                  inflight_reg, inflight_next;
  logic                  rd_bank_reg,  rd_bank_next; // bank the in-flight read came from

  // Per-cycle decisions
  logic                  in_ready_w;
  logic                  push;
  logic                  pop;
  logic [1:0]            obuf_after_pop;
  logic                  bypass_ok;
  logic                  byp_wr;
  logic                  ram_wr;
  logic                  rd_want;
  logic                  bank_conflict;
  logic                  ram_rd;
  logic                  ld_en;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] ram_q;

  // Flags depend only on registered count (and flush for in_ready).
  assign in_ready_w    = (count_reg < DEPTH_C) & ~flush;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (obuf_cnt_reg != 2'd0);
  assign bus.out_data  = obuf0_reg;
  assign count         = count_reg;
  assign almost_full   = (count_reg >= AFULL_C);
  assign almost_empty  = (count_reg <= AEMPTY_C);

  // --------------------------------------------------------------------------
  // RAM banks: one access per bank per cycle, registered read. Contents are
  // never cleared; the counters alone say which words are live.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
      logic [DATA_WIDTH-1:0] q_reg;
      logic                  we;
      logic                  re;
      logic [BANK_AW-1:0]    addr;

      // bank_conflict guarantees we and re are never both set here.
      assign we   = ram_wr & (wr_ptr_reg[0] == 1'(gi));
      assign re   = ram_rd & (rd_ptr_reg[0] == 1'(gi));
      assign addr = we ? wr_ptr_reg[PTR_W-1:1] : rd_ptr_reg[PTR_W-1:1];

      always_ff @(posedge clk) begin
        if (we) begin
          mem[addr] <= bus.in_data;
        end else if (re) begin
          q_reg <= mem[addr];
        end
      end
    end
  endgenerate

  assign ram_q = rd_bank_reg ? g_bank[1].q_reg : g_bank[0].q_reg;

  // --------------------------------------------------------------------------
  // Datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    push           = bus.in_valid & in_ready_w;
    pop            = (obuf_cnt_reg != 2'd0) & bus.out_ready & ~flush;
    obuf_after_pop = obuf_cnt_reg - {1'b0, pop};

    // Bypass only when nothing older sits in RAM or in the read pipe, so a
    // bypassed word can never overtake RAM-resident data.
    bypass_ok = (ram_cnt_reg == '0) & ~inflight_reg & (obuf_after_pop != 2'd2);
    byp_wr    = push & bypass_ok;
    ram_wr    = push & ~bypass_ok;

    // Prefetch only if the returning word is guaranteed a buffer slot.
    rd_want = ~flush & (ram_cnt_reg != '0) &
              ((obuf_after_pop + {1'b0, inflight_reg}) < 2'd2);

    // Write wins a same-bank clash. The write moves wr_ptr to the other bank,
    // so the deferred read cannot clash again on the following cycle.
    bank_conflict = rd_want & ram_wr & (wr_ptr_reg[0] == rd_ptr_reg[0]);
    ram_rd        = rd_want & ~bank_conflict;

    // At most one buffer load per cycle: a bypass needs inflight==0.
    ld_en   = inflight_reg | byp_wr;
    ld_data = inflight_reg ? ram_q : bus.in_data;

    obuf0_next = pop ? obuf1_reg : obuf0_reg;
    obuf1_next = obuf1_reg;
    if (ld_en) begin
      if (obuf_after_pop == 2'd0) begin
        obuf0_next = ld_data;
      end else begin
        obuf1_next = ld_data;
      end
    end
    obuf_cnt_next = obuf_after_pop + {1'b0, ld_en};

    inflight_next = ram_rd;
    rd_bank_next  = ram_rd ? rd_ptr_reg[0] : rd_bank_reg;
    wr_ptr_next   = wr_ptr_reg + PTR_W'(ram_wr);
    rd_ptr_next   = rd_ptr_reg + PTR_W'(ram_rd);
    ram_cnt_next  = ram_cnt_reg + CNT_W'(ram_wr) - CNT_W'(ram_rd);
    count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ram_cnt_reg  <= '0;
      count_reg    <= '0;
      obuf_cnt_reg <= '0;
      obuf0_reg    <= '0;
      obuf1_reg    <= '0;
      inflight_reg <= 1'b0;
      rd_bank_reg  <= 1'b0;
    end else if (flush) begin
      // A read returning this cycle is dropped along with everything else.
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ram_cnt_reg  <= '0;
      count_reg    <= '0;
      obuf_cnt_reg <= '0;
      obuf0_reg    <= '0;
      obuf1_reg    <= '0;
      inflight_reg <= 1'b0;
      rd_bank_reg  <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      ram_cnt_reg  <= ram_cnt_next;
      count_reg    <= count_next;
      obuf_cnt_reg <= obuf_cnt_next;
      obuf0_reg    <= obuf0_next;
      obuf1_reg    <= obuf1_next;
      inflight_reg <= inflight_next;
      rd_bank_reg  <= rd_bank_next;
    end
  end

endmodule

// File: tb/tb_fifo_spram_2bank.sv
// ----------------------------------------------------------------------------
// tb_fifo_spram_2bank
// Self-checking bench for fifo_spram_2bank (DATA_WIDTH=8, FIFO_DEPTH=16).
// A queue model tracks contents; every negedge the DUT's count, flags and
// head word are compared against it. Directed sequences pin literal values.
// ----------------------------------------------------------------------------
module tb_fifo_spram_2bank;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;

  fifo_spram_2bank_if #(.DATA_WIDTH(DW)) bus ();

  fifo_spram_2bank #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: an ordered queue of accepted words.
  // --------------------------------------------------------------------------
  logic [DW-1:0] model_q[$];
  int            m_sz;
  int            m_pops    = 0;
  int            stall_run = 0;
  int            conflicts = 0;
  bit            m_pop;
  bit            m_push;

  always @(negedge rst_n) model_q.delete();

  always @(negedge clk) begin
    if (rst_n) begin
      m_sz = model_q.size();
      chk("m_count", 32'(count), 32'(m_sz));
      chk("m_in_ready", 32'(bus.in_ready), 32'((m_sz < DEPTH) && !flush));
      chk("m_almost_full", 32'(almost_full), 32'(m_sz >= DEPTH - 2));
      chk("m_almost_empty", 32'(almost_empty), 32'(m_sz <= 2));
      if (m_sz == 0) begin
        chk("m_out_valid_empty", 32'(bus.out_valid), 32'(0));
      end else if (bus.out_valid) begin
        chk("m_out_data", 32'(bus.out_data), 32'(model_q[0]));
      end
      // Data held but not presented: tolerated only for a few cycles.
      if (m_sz != 0 && !bus.out_valid) stall_run++;
      else stall_run = 0;
      if (m_sz != 0) chk("m_stall_bound", 32'(stall_run > 4), 32'(0));

      if (dut.bank_conflict) conflicts++;

      if (flush) begin
        model_q.delete();
      end else begin
        m_pop  = bus.out_valid && bus.out_ready;
        m_push = bus.in_valid && (m_sz < DEPTH);
        if (m_pop && model_q.size() > 0) begin
          void'(model_q.pop_front());
          m_pops++;
        end
        if (m_push) model_q.push_back(bus.in_data);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (model_q.size() == 0) break;
      step();
    end
    bus.out_ready = 1'b0;
    step();
    chk(name, 32'(count), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p0;
  int c0;
  int cyc;

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #23;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_almost_full", 32'(almost_full), 32'(0));
    chk("rst_almost_empty", 32'(almost_empty), 32'(1));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    step();

    // Single word through the bypass: visible right after the push edge.
    push_word(8'hA5);
    chk("byp_out_valid", 32'(bus.out_valid), 32'(1));
    chk("byp_out_data", 32'(bus.out_data), 32'(8'hA5));
    chk("byp_count", 32'(count), 32'(1));
    chk("byp_almost_empty", 32'(almost_empty), 32'(1));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("byp_pop_count", 32'(count), 32'(0));

    // Fill to full, then drain back-to-back.
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", 32'(bus.in_ready), 32'(0));
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 32'(bus.out_valid), 32'(1));
      chk("drain_data", 32'(bus.out_data), 32'(i));
      step();
    end
    bus.out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'(0));
    chk("drain_valid_end", 32'(bus.out_valid), 32'(0));

    // Streaming: 4 preloaded, then push and pop every cycle. The start of the
    // stream hits a same-bank clash; the deferred read costs one bubble.
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    p0 = m_pops;
    c0 = conflicts;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 120; k++) begin
      bus.in_data = DW'($urandom);
      step();
      cyc = k;
      if (m_pops - p0 >= 100) break;
    end
    chk("stream_pops", 32'(m_pops - p0 >= 100), 32'(1));
    chk("stream_cycles", 32'(cyc <= 101), 32'(1));
    chk("stream_conflict", 32'(conflicts > c0), 32'(1));
    drain("stream_drain");

    // Full with simultaneous push and pop: push refused, pop honoured.
    for (int i = 0; i < DEPTH; i++) push_word(DW'(8'h40 + i));
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h99;
    bus.out_ready = 1'b1;
    chk("fullpp_count_pre", 32'(count), 32'(16));
    chk("fullpp_in_ready", 32'(bus.in_ready), 32'(0));
    chk("fullpp_head_pre", 32'(bus.out_data), 32'(8'h40));
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("fullpp_count_post", 32'(count), 32'(15));
    chk("fullpp_head_post", 32'(bus.out_data), 32'(8'h41));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fullpp_flush_count", 32'(count), 32'(0));

    // Flush with 9 words held, then one fresh word.
    for (int i = 0; i < 9; i++) push_word(DW'(8'h60 + i));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_out_valid", 32'(bus.out_valid), 32'(0));
    push_word(8'h3C);
    chk("flush_new_valid", 32'(bus.out_valid), 32'(1));
    chk("flush_new_data", 32'(bus.out_data), 32'(8'h3C));
    chk("flush_new_count", 32'(count), 32'(1));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("flush_only_word", 32'(bus.out_valid), 32'(0));

    // Asynchronous reset between edges with 7 words held.
    for (int i = 0; i < 7; i++) push_word(DW'(8'h70 + i));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'(0));
    chk("arst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("arst_out_data", 32'(bus.out_data), 32'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    push_word(8'h11);
    chk("arst_first_valid", 32'(bus.out_valid), 32'(1));
    chk("arst_first_data", 32'(bus.out_data), 32'(8'h11));
    chk("arst_first_count", 32'(count), 32'(1));
    drain("arst_drain");

    // Random traffic in phases biased toward full, balanced and empty.
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 200; k++) begin
        bus.in_data   = DW'($urandom);
        bus.in_valid  = ($urandom_range(0, 99) < (ph == 0 ? 85 : ph == 3 ? 25 : 60));
        bus.out_ready = ($urandom_range(0, 99) < (ph == 0 ? 25 : ph == 3 ? 85 : 60));
        flush         = ($urandom_range(0, 99) < 2);
        step();
      end
      flush = 1'b0;
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
